// File: rtl/safety_mute_ctrl_pkg.sv
// Shared types and helpers for the RF safety mute controller.
// Holds the FSM encoding and gain/counter sizing.
package am_safety_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    FAULT     = 3'd4
  } state_e;

  localparam int FCW = 8;

  function automatic logic [31:0] gain_max(int unsigned w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/safety_mute_ctrl_if.sv
// Control/status bundle between host, watchdog and the mute controller.
// master drives requests, slave is the controller.
interface safety_mute_if #(
  parameter int GAIN_WIDTH = 16
);
  import am_safety_pkg::*;

  logic                  wd_triggered;
  logic                  wd_warning;
  logic                  estop;
  logic                  rf_enable_req;
  logic                  clear_fault;
  logic [GAIN_WIDTH-1:0] gain;
  logic                  rf_active;
  logic                  muted;
  logic                  fault_latched;
  logic                  warn_out;
  logic [2:0]            state;
  logic [FCW-1:0]        fault_count;

  modport master (
    output wd_triggered, wd_warning, estop,
    output rf_enable_req, clear_fault,
    input  gain, rf_active, muted,
    input  fault_latched, warn_out,
    input  state, fault_count
  );

  modport slave (
    input  wd_triggered, wd_warning, estop,
    input  rf_enable_req, clear_fault,
    output gain, rf_active, muted,
    output fault_latched, warn_out,
    output state, fault_count
  );

endinterface

// File: rtl/safety_mute_ctrl_ramp_tick_gen.sv
// Ramp tick divider: one tick every DIV enabled cycles.
// Sync clear restarts the phase so the first tick lands DIV cycles later.
module ramp_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/safety_mute_ctrl.sv
// RF gain safety controller: ramps modulator gain, latches faults
// on watchdog timeout or e-stop and mutes until a gated host clear.
module safety_mute_ctrl
  import am_safety_pkg::*;
#(
  parameter int GAIN_WIDTH     = 16,
  parameter int RAMP_STEP      = 4096,
  parameter int RAMP_DIV       = 4,
  parameter int HOLDOFF_CYCLES = 8
) (
  input  logic         clk,
  input  logic         rstn,
  safety_mute_if.slave bus
);

  localparam int GW = GAIN_WIDTH;
  localparam int HW = (HOLDOFF_CYCLES > 0) ?
                      $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GMAX = GW'(gain_max(GW));
  localparam logic [GW:0]   STEP = (GW+1)'(RAMP_STEP);
  localparam logic [HW-1:0] HOLD = HW'(HOLDOFF_CYCLES);

  state_e         state_q, state_d;
  logic [GW-1:0]  gain_q, gain_d;
  logic           fault_q, fault_d;
  logic           muted_q, muted_d;
  logic           rf_q, rf_d;
  logic           warn_q;
  logic [FCW-1:0] cnt_q, cnt_d;
  logic [HW-1:0]  hold_q, hold_d;

  logic          tick, tick_clr, tick_en;
  logic [GW:0]   up_w;
  logic [GW-1:0] gain_up, gain_dn;
  logic          at_zero, hold_done, clr_ok;

  assign tick_en  = (state_q == RAMP_UP) ||
                    (state_q == RAMP_DOWN);
  assign tick_clr = (state_d != state_q) &&
                    ((state_d == RAMP_UP) ||
                     (state_d == RAMP_DOWN));

  ramp_tick_gen #(.DIV(RAMP_DIV)) u_tick (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (tick_clr),
    .en_i   (tick_en),
    .tick_o (tick)
  );

  // Widened arithmetic clamps instead of wrapping.
  assign up_w    = {1'b0, gain_q} + STEP;
  assign gain_up = (up_w > {1'b0, GMAX}) ? GMAX : up_w[GW-1:0];
  assign gain_dn = ({1'b0, gain_q} < STEP) ? '0 :
                   gain_q - STEP[GW-1:0];

  assign at_zero   = (gain_q == '0) || (tick && gain_dn == '0);
  assign hold_done = (hold_q == HOLD);
  assign clr_ok    = bus.clear_fault && hold_done &&
                     !bus.wd_triggered && !bus.estop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      gain_q  <= '0;
      fault_q <= 1'b0;
      muted_q <= 1'b1;
      rf_q    <= 1'b0;
      warn_q  <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      fault_q <= fault_d;
      muted_q <= muted_d;
      rf_q    <= rf_d;
      warn_q  <= bus.wd_warning;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    if (bus.estop || bus.wd_triggered) fault_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (bus.estop || bus.wd_triggered) state_d = FAULT;
        else if (bus.rf_enable_req)        state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (bus.estop)                   state_d = FAULT;
        else if (bus.wd_triggered)       state_d = RAMP_DOWN;
        else if (!bus.rf_enable_req)     state_d = RAMP_DOWN;
        else if (tick && gain_up == GMAX) state_d = RUN;
      end
      RUN: begin
        if (bus.estop) state_d = FAULT;
        else if (bus.wd_triggered || !bus.rf_enable_req)
          state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (bus.estop)   state_d = FAULT;
        else if (at_zero) state_d = fault_d ? FAULT : IDLE;
        else if (bus.rf_enable_req && !fault_q &&
                 !bus.wd_triggered)
          state_d = RAMP_UP;
      end
      FAULT: begin
        if (clr_ok) begin
          state_d = IDLE;
          fault_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gain_d = gain_q;
    unique case (state_d)
      RUN:       gain_d = GMAX;
      RAMP_UP:   if (state_q == RAMP_UP && tick) gain_d = gain_up;
      RAMP_DOWN: if (state_q == RAMP_DOWN && tick) gain_d = gain_dn;
      default:   gain_d = '0;
    endcase
    muted_d = (gain_d == '0);
    rf_d    = (state_d == RUN);
    cnt_d   = cnt_q;
    if (fault_d && !fault_q && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    hold_d = '0;
    if (state_q == FAULT) hold_d = hold_done ? hold_q : hold_q + 1'b1;
  end

  assign bus.gain          = gain_q;
  assign bus.rf_active     = rf_q;
  assign bus.muted         = muted_q;
  assign bus.fault_latched = fault_q;
  assign bus.warn_out      = warn_q;
  assign bus.state         = state_q;
  assign bus.fault_count   = cnt_q;

endmodule

// File: doc/safety_mute_ctrl.md
Name: safety_mute_ctrl

Overview:
Consumes the watchdog timer's triggered and warning outputs, plus a hardware e-stop and host RF-enable request, and produces the RF gain word for the AM modulator. Ramps gain up and down in steps to avoid click/splatter on the carrier. Latches a fault on watchdog timeout or e-stop, and holds the output muted until the host clears the fault after a minimum hold-off. Sits between the watchdog timer and the AM modulator's gain multiplier.

Parameters:
GAIN_WIDTH, 16, width of gain word; GAIN_MAX = 2^GAIN_WIDTH-1
RAMP_STEP, 4096, gain increment/decrement per ramp tick
RAMP_DIV, 4, clock cycles per ramp tick (>=1)
HOLDOFF_CYCLES, 8, minimum cycles in FAULT before clear_fault is accepted

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous assert, active-low
wd_triggered  in  1  watchdog timeout (level)
wd_warning  in  1  watchdog warning (level)
estop  in  1  emergency stop (level, highest priority)
rf_enable_req  in  1  host requests RF on (level)
clear_fault  in  1  host fault-clear (single-cycle pulse)
gain  out  GAIN_WIDTH  registered gain to modulator
rf_active  out  1  high only in RUN
muted  out  1  high when gain==0
fault_latched  out  1  sticky fault flag
warn_out  out  1  wd_warning registered (1-cycle delay)
state  out  3  current FSM state encoding
fault_count  out  8  number of fault latch events, saturating at 255

Behaviour:
- Reset (async, rstn=0): state=IDLE, gain=0, muted=1, rf_active=0, fault_latched=0, warn_out=0, fault_count=0, tick divider=0, holdoff counter=0.
- All outputs registered. Input priority within a cycle: estop > wd_triggered > rf_enable_req.
- Ramp tick: divider clears on entry to RAMP_UP/RAMP_DOWN. First tick fires RAMP_DIV cycles after entry, then every RAMP_DIV cycles.
- Gain arithmetic: up = min(gain+RAMP_STEP, GAIN_MAX); down = max(gain-RAMP_STEP, 0). Computed at GAIN_WIDTH+1 bits; never wraps.
- Fault event (fault_latched 0->1): fault_count += 1, saturating at 255. Re-assertion while already latched does not count.
- IDLE: gain=0.
  - estop -> FAULT (latch).
  - wd_triggered -> FAULT (latch).
  - rf_enable_req -> RAMP_UP.
- RAMP_UP: gain steps up on each tick.
  - Reaching GAIN_MAX -> RUN.
  - estop -> FAULT with gain=0 on the next cycle (no ramp).
  - wd_triggered -> latch fault, go to RAMP_DOWN from current gain.
  - rf_enable_req=0 -> RAMP_DOWN (no latch).
- RUN: gain=GAIN_MAX, rf_active=1.
  - estop -> FAULT with gain=0 next cycle.
  - wd_triggered -> latch, RAMP_DOWN.
  - rf_enable_req=0 -> RAMP_DOWN.
- RAMP_DOWN: gain steps down on each tick.
  - At gain==0: go to FAULT if fault_latched, else IDLE.
  - estop -> FAULT, gain=0 next cycle.
  - rf_enable_req=1 with fault_latched=0 and wd_triggered=0 -> RAMP_UP from current gain.
- FAULT: gain=0, fault_latched=1.
  - Holdoff counter clears on entry and counts to HOLDOFF_CYCLES, then saturates.
  - clear_fault is accepted only when holdoff is done, wd_triggered=0 and estop=0. Then go to IDLE and clear fault_latched the next cycle.
  - clear_fault outside those conditions is ignored and not queued.
  - The IDLE entered after a clear does not auto-restart RF. IDLE->RAMP_UP follows normal rules on the next cycle.
- wd_warning has no effect on gain; it only drives warn_out.
- Simultaneous clear_fault and estop: estop wins, stay in FAULT.

Decomposition:
- Package am_safety_pkg holds the state enum (IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, FAULT=4), the GAIN_MAX function, and fault_count width.
- One sub-module: ramp_tick_gen, a RAMP_DIV divider with sync clear and a tick output.

Test Plan:
- Reset, then rf_enable_req=1 -> RAMP_UP next cycle. Gain 4096 at tick 1, 61440 after 15 ticks, 65535 after 16 ticks (64 cycles); state RUN, rf_active=1.
- In RUN, assert wd_triggered -> fault_latched=1, fault_count=1. Gain decrements by 4096 every 4 cycles to 0, then FAULT, muted=1.
- In FAULT, clear_fault at entry+3 -> ignored. Drop wd_triggered, clear_fault at entry+9 -> IDLE, fault_latched=0.
- In RUN, assert estop -> gain=0 and state=FAULT one cycle later, no ramp.
- In RAMP_UP at gain=8192, drop rf_enable_req -> ramp down to 0 -> IDLE, fault_latched=0.
- Force 256 fault events -> fault_count holds 255. Assert rstn=0 mid-RAMP_UP -> all outputs go to reset values immediately (async).
